// File: rtl/pipearch_rdarb_pkg.sv
// -----------------------------------------------------------------------------
// pipearch_rdarb_pkg
// Shared constants and helpers for the region read arbiter slice.
//   RDARB_NUM_REQ_DEF   : default number of requesters
//   RDARB_TAG_DEPTH_DEF : default maximum outstanding reads
//   rdarb_idx_w()       : width of a requester index / tag, minimum 1 bit
// -----------------------------------------------------------------------------
package pipearch_rdarb_pkg;

    localparam int unsigned RDARB_NUM_REQ_DEF   = 4;
    localparam int unsigned RDARB_TAG_DEPTH_DEF = 4;

    // clog2(n) but never zero, so a single-bit tag exists even for n <= 2.
    function automatic int unsigned rdarb_idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned RDARB_TAG_W_DEF = rdarb_idx_w(RDARB_NUM_REQ_DEF);

endpackage

// File: rtl/pipearch_tag_fifo.sv
// -----------------------------------------------------------------------------
// pipearch_tag_fifo
// In-order storage for requester tags of reads in flight. Head is available
// combinationally (no read latency). Pointers wrap naturally; the occupancy
// count is kept separately so full and empty are unambiguous.
// Ports:
//   i_clk, i_reset : clock, synchronous active-high reset (flushes the FIFO)
//   i_push, i_tag  : write a tag (ignored when full)
//   i_pop          : drop the head entry (ignored when empty)
//   o_head         : oldest tag
//   o_count        : number of entries, 0..DEPTH
//   o_full/o_empty : occupancy flags
// -----------------------------------------------------------------------------
module pipearch_tag_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 2
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_tag,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_push;
    logic w_pop;

    assign o_full  = (r_count == CNT_W'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;

    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop  && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_tag;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
        end
        if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        end
        if (w_push && !w_pop) begin
            r_count <= r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            r_count <= r_count - CNT_W'(1);
        end
        if (i_reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end
    end

endmodule

// File: rtl/pipearch_region_read_arbiter.sv
// -----------------------------------------------------------------------------
// pipearch_region_read_arbiter
// Round-robin sharing of one fifobram region read port among NUM_REQ op units.
// Each issued read's requester index is queued in an in-order tag FIFO and the
// returning data is steered back to that requester.
// Ports:
//   clk, reset              : clock, synchronous active-high reset
//   req_re / req_raddr      : per-requester read request (held until granted)
//   req_grant               : one-hot, combinational grant this cycle
//   rsp_rvalid / rsp_rdata  : one-hot response valid, shared data bus
//   bram_re / bram_raddr    : registered read command to the region
//   bram_rvalid / bram_rdata: region read return
//   outstanding             : reads in flight
//   err_orphan              : sticky, data returned with nothing in flight
// Optional: define PIPEARCH_RDARB_STATS_EN to add stat_grants (per-requester
// grant counters) and stat_full_stall (cycles blocked by a full tag FIFO).
// -----------------------------------------------------------------------------
module pipearch_region_read_arbiter
    import pipearch_rdarb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = RDARB_NUM_REQ_DEF,
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 512,
    parameter int unsigned TAG_DEPTH = RDARB_TAG_DEPTH_DEF
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_REQ-1:0]              req_re,
    input  logic [NUM_REQ-1:0][ADDR_W-1:0]  req_raddr,
    output logic [NUM_REQ-1:0]              req_grant,
    output logic [NUM_REQ-1:0]              rsp_rvalid,
    output logic [DATA_W-1:0]               rsp_rdata,
    output logic                            bram_re,
    output logic [ADDR_W-1:0]               bram_raddr,
    input  logic                            bram_rvalid,
    input  logic [DATA_W-1:0]               bram_rdata,
    output logic [$clog2(TAG_DEPTH):0]      outstanding,
    output logic                            err_orphan
`ifdef PIPEARCH_RDARB_STATS_EN
    ,
    output logic [NUM_REQ-1:0][31:0]        stat_grants,
    output logic [31:0]                     stat_full_stall
`endif
);

    localparam int unsigned IDX_W = rdarb_idx_w(NUM_REQ);
    localparam int unsigned CNT_W = $clog2(TAG_DEPTH) + 1;

    logic [IDX_W-1:0]       r_rr_ptr;

    logic                   w_issue_ok;
    logic                   w_grant_any;
    logic [IDX_W-1:0]       w_grant_idx;
    logic [IDX_W:0]         w_scan;
    logic [2*NUM_REQ-1:0]   w_rot;
    logic [NUM_REQ-1:0]     w_grant;
    logic                   w_pop;
    logic [IDX_W-1:0]       w_head;
    logic [CNT_W-1:0]       w_count;
    logic                   w_full;
    logic                   w_empty;

    // Issue only while the registered count shows a free slot; a pop in the
    // same cycle is not credited until the next cycle.
    assign w_issue_ok = !w_full;

    // Rotate requests so bit 0 is the current round-robin starting point,
    // take the first set bit, then map back to an absolute requester index.
    assign w_rot = {req_re, req_re} >> r_rr_ptr;

    always_comb begin
        w_grant_any = 1'b0;
        w_grant_idx = '0;
        w_scan      = '0;
        w_grant     = '0;
        if (w_issue_ok) begin
            for (int unsigned j = 0; j < NUM_REQ; j++) begin
                if (!w_grant_any && w_rot[j]) begin
                    w_grant_any = 1'b1;
                    w_scan      = {1'b0, r_rr_ptr} + (IDX_W+1)'(j);
                    if (w_scan >= (IDX_W+1)'(NUM_REQ)) begin
                        w_scan = w_scan - (IDX_W+1)'(NUM_REQ);
                    end
                    w_grant_idx = w_scan[IDX_W-1:0];
                end
            end
        end
        if (w_grant_any) begin
            w_grant[w_grant_idx] = 1'b1;
        end
    end

    assign req_grant   = w_grant;
    assign w_pop       = bram_rvalid && !w_empty;
    assign outstanding = w_count;

    pipearch_tag_fifo #(
        .DEPTH (TAG_DEPTH),
        .WIDTH (IDX_W)
    ) u_tag_fifo (
        .i_clk   (clk),
        .i_reset (reset),
        .i_push  (w_grant_any),
        .i_tag   (w_grant_idx),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge clk) begin
        bram_re <= w_grant_any;
        if (w_grant_any) begin
            bram_raddr <= req_raddr[w_grant_idx];
            r_rr_ptr   <= (w_grant_idx == IDX_W'(NUM_REQ - 1)) ? '0
                                                                : w_grant_idx + IDX_W'(1);
        end

        rsp_rvalid <= '0;
        if (bram_rvalid) begin
            if (w_empty) begin
                err_orphan <= 1'b1;
            end else begin
                rsp_rvalid[w_head] <= 1'b1;
                rsp_rdata          <= bram_rdata;
            end
        end

`ifdef PIPEARCH_RDARB_STATS_EN
        if (w_grant_any) begin
            stat_grants[w_grant_idx] <= stat_grants[w_grant_idx] + 32'd1;
        end
        if ((|req_re) && !w_issue_ok) begin
            stat_full_stall <= stat_full_stall + 32'd1;
        end
`endif

        // Reset is written last so it overrides every assignment above.
        if (reset) begin
            bram_re    <= 1'b0;
            bram_raddr <= '0;
            rsp_rvalid <= '0;
            rsp_rdata  <= '0;
            err_orphan <= 1'b0;
            r_rr_ptr   <= '0;
`ifdef PIPEARCH_RDARB_STATS_EN
            stat_grants     <= '0;
            stat_full_stall <= '0;
`endif
        end
    end

endmodule

// File: tb/tb_pipearch_region_read_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pipearch_region_read_arbiter
// Randomized requesters and a region model with configurable read latency.
// A reference model at the falling edge predicts grants, the region command,
// occupancy and orphan state; expected responses are queued at grant time and
// popped when a response is due.
// -----------------------------------------------------------------------------
module tb_pipearch_region_read_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 512;
    localparam int unsigned TD = 4;

    logic                   clk = 1'b0;
    logic                   reset = 1'b1;
    logic [NR-1:0]          req_re = '0;
    logic [NR-1:0][AW-1:0]  req_raddr = '0;
    logic [NR-1:0]          req_grant;
    logic [NR-1:0]          rsp_rvalid;
    logic [DW-1:0]          rsp_rdata;
    logic                   bram_re;
    logic [AW-1:0]          bram_raddr;
    logic                   bram_rvalid = 1'b0;
    logic [DW-1:0]          bram_rdata = '0;
    logic [$clog2(TD):0]    outstanding;
    logic                   err_orphan;

    always #5 clk = ~clk;

    pipearch_region_read_arbiter #(
        .NUM_REQ   (NR),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .TAG_DEPTH (TD)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_re      (req_re),
        .req_raddr   (req_raddr),
        .req_grant   (req_grant),
        .rsp_rvalid  (rsp_rvalid),
        .rsp_rdata   (rsp_rdata),
        .bram_re     (bram_re),
        .bram_raddr  (bram_raddr),
        .bram_rvalid (bram_rvalid),
        .bram_rdata  (bram_rdata),
        .outstanding (outstanding),
        .err_orphan  (err_orphan)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Region contents: every line is a distinct function of its address.
    function automatic logic [DW-1:0] mem_data(input logic [AW-1:0] a);
        logic [DW-1:0] d;
        for (int k = 0; k < DW / 16; k++) begin
            d[k*16 +: 16] = a ^ 16'(k * 40503) ^ 16'(k << 9);
        end
        return d;
    endfunction

    // ---------------- region model ----------------
    typedef struct {
        logic [AW-1:0] addr;
        int unsigned   due;
    } rd_t;

    rd_t         region_q[$];
    int unsigned cyc = 0;
    int unsigned lat = 1;
    bit          inject_orphan = 0;

    // ---------------- requester controls ----------------
    logic [NR-1:0] req_mask = '0;
    int unsigned   req_prob = 0;
    logic [NR-1:0] last_gnt = '0;

    // ---------------- reference model ----------------
    typedef struct {
        int unsigned   req;
        logic [DW-1:0] data;
    } rsp_t;

    rsp_t          sb_q[$];
    int unsigned   m_rr = 0;
    int unsigned   m_cnt = 0;
    logic          exp_bre = 1'b0;
    logic [AW-1:0] exp_baddr = '0;
    bit            exp_rsp_pend = 0;
    logic [DW-1:0] exp_rdata = '0;
    logic          m_err = 1'b0;
    bit            chk_en = 0;

    always @(negedge clk) begin
        if (chk_en) begin
            logic [NR-1:0] exp_g;
            logic [NR-1:0] oh;
            int            g;
            bit            pop;
            rsp_t          e;

            check("bram_re", DW'(bram_re), DW'(exp_bre));
            check("bram_raddr", DW'(bram_raddr), DW'(exp_baddr));
            check("outstanding", DW'(outstanding), DW'(m_cnt));
            check("err_orphan", DW'(err_orphan), DW'(m_err));

            if (exp_rsp_pend) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_scoreboard_empty t=%0t", $time);
                end else begin
                    e  = sb_q.pop_front();
                    oh = '0;
                    oh[e.req] = 1'b1;
                    exp_rdata = e.data;
                    check("rsp_rvalid", DW'(rsp_rvalid), DW'(oh));
                end
            end else begin
                check("rsp_rvalid_idle", DW'(rsp_rvalid), '0);
            end
            check("rsp_rdata", rsp_rdata, exp_rdata);

            // Round-robin: first requester at or after m_rr, modulo NR.
            exp_g = '0;
            g     = -1;
            if (m_cnt < TD) begin
                for (int k = 0; k < NR; k++) begin
                    int idx;
                    idx = (m_rr + k) % NR;
                    if (g < 0 && req_re[idx]) g = idx;
                end
            end
            if (g >= 0) exp_g[g] = 1'b1;
            check("req_grant", DW'(req_grant), DW'(exp_g));
            last_gnt = req_grant;

            pop = bram_rvalid && (m_cnt > 0);
            if (bram_rvalid && m_cnt == 0) m_err = 1'b1;
            exp_rsp_pend = pop;
            if (g >= 0) begin
                sb_q.push_back('{req: g, data: mem_data(req_raddr[g])});
                exp_bre   = 1'b1;
                exp_baddr = req_raddr[g];
                m_rr      = (g + 1) % NR;
                m_cnt     = m_cnt + 1;
            end else begin
                exp_bre = 1'b0;
            end
            if (pop) m_cnt = m_cnt - 1;

            if (reset) begin
                m_rr         = 0;
                m_cnt        = 0;
                exp_bre      = 1'b0;
                exp_baddr    = '0;
                exp_rsp_pend = 0;
                exp_rdata    = '0;
                m_err        = 1'b0;
                sb_q.delete();
            end
        end
    end

    // One clock of stimulus: region model then requesters, driven #1 after the edge.
    task automatic step();
        rd_t r;
        @(posedge clk);
        #1;
        cyc++;
        if (reset) begin
            region_q.delete();
        end else if (bram_re) begin
            region_q.push_back('{addr: bram_raddr, due: cyc + lat});
        end
        bram_rvalid = 1'b0;
        for (int k = 0; k < DW / 32; k++) bram_rdata[k*32 +: 32] = $urandom;
        if (!reset && region_q.size() > 0 && region_q[0].due <= cyc) begin
            r           = region_q.pop_front();
            bram_rvalid = 1'b1;
            bram_rdata  = mem_data(r.addr);
        end else if (!reset && inject_orphan && region_q.size() == 0) begin
            bram_rvalid   = 1'b1;
            inject_orphan = 0;
        end
        for (int i = 0; i < NR; i++) begin
            if (req_re[i] && last_gnt[i]) req_re[i] = 1'b0;
            if (!req_re[i] && req_mask[i] && $urandom_range(99) < req_prob) begin
                req_re[i]    = 1'b1;
                req_raddr[i] = AW'($urandom);
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run(2);
        reset = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        req_mask = '0;
        while ((req_re != '0 || m_cnt != 0 || region_q.size() != 0 || exp_rsp_pend) && n < 300) begin
            step();
            n++;
        end
        checks++;
        if (n >= 300) begin
            failures++;
            $display("FAIL drain_timeout actual=%0d required=<300 t=%0t", n, $time);
        end
    endtask

    initial begin
        @(posedge clk);
        chk_en = 1;
        run(2);
        reset = 1'b0;

        // Single request from requester 2, region latency 1.
        lat = 1;
        req_re[2]    = 1'b1;
        req_raddr[2] = 16'h0010;
        run(6);

        // All four requesting continuously from rr_ptr = 0.
        do_reset();
        req_prob = 100;
        req_mask = 4'hF;
        run(16);
        drain();

        // Slow region: tag FIFO fills and grants stall.
        lat = 10;
        req_prob = 100;
        req_mask = 4'hF;
        run(30);
        drain();

        // Random mix, varying latency, many pointer wraps.
        for (int p = 0; p < 15; p++) begin
            lat      = $urandom_range(1, 4);
            req_prob = $urandom_range(30, 90);
            req_mask = NR'($urandom_range(1, 15));
            run(20);
        end
        drain();

        // Orphan return, sticky until reset.
        inject_orphan = 1;
        run(5);
        do_reset();
        run(2);

        // Reset with three reads in flight.
        lat = 10;
        req_raddr[0] = 16'h0100;
        req_raddr[1] = 16'h0101;
        req_raddr[2] = 16'h0102;
        req_re       = 4'b0111;
        run(3);
        check("outstanding_before_reset", DW'(outstanding), DW'(3));
        reset = 1'b1;
        step();
        check("outstanding_after_reset", DW'(outstanding), '0);
        check("rsp_rvalid_after_reset", DW'(rsp_rvalid), '0);
        reset = 1'b0;
        req_raddr[1] = 16'h0201;
        req_raddr[3] = 16'h0203;
        req_re       = 4'b1010;
        #1;
        check("grant_lowest_after_reset", DW'(req_grant), DW'(4'b0010));
        lat = 2;
        drain();
        run(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

endmodule
